// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the scaled VGA scan-out engine.
// Default 640x480@60 timing, derivation helpers for line/frame totals and
// framebuffer width, sync-polarity constants and the pipelined control record.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Control bits that travel alongside the RAM read so they line up with data.
    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic fs;
    } vga_ctl_t;

    // Total clocks per line (or lines per frame) from active + porches + sync.
    function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // Source framebuffer width in pixels for a given replication shift.
    function automatic int unsigned fb_width(input int unsigned h_act, input int unsigned shift);
        return h_act >> shift;
    endfunction

endpackage

// File: rtl/vga_scaled_scanout_if.sv
// vga_scaled_scanout_if: bundles the framebuffer read port and the VGA pins.
//   base_addr   : frame base address (sampled by the engine at frame boundary)
//   color_in    : RAM read data
//   addr        : RAM read address, addr_valid flags visible-pixel fetches
//   hsync/vsync : sync outputs, color_out/active/frame_start : pixel stream
// master = scan-out engine, slave = environment (RAM + display side).
interface vga_scaled_scanout_if #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned COLOR_W = 8
);
    logic [ADDR_W-1:0]  base_addr;
    logic [COLOR_W-1:0] color_in;
    logic [ADDR_W-1:0]  addr;
    logic               addr_valid;
    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] color_out;
    logic               active;
    logic               frame_start;

    modport master (
        input  base_addr, color_in,
        output addr, addr_valid, hsync, vsync, color_out, active, frame_start
    );

    modport slave (
        output base_addr, color_in,
        input  addr, addr_valid, hsync, vsync, color_out, active, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running horizontal/vertical counters with stage-0 decode.
//   clk, rst : pixel clock, synchronous active-high reset
//   h_cnt    : 0..H_TOTAL-1,  v_cnt : 0..V_TOTAL-1
//   ctl0     : {vis, hs, vs, fs} decoded from the current counter position
//   eol      : last clock of a line,  eof : last clock of a frame
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned H_W      = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1),
    parameter int unsigned V_W      = $clog2(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1)
) (
    input  logic           clk,
    input  logic           rst,
    output logic [H_W-1:0] h_cnt,
    output logic [V_W-1:0] v_cnt,
    output vga_ctl_t       ctl0,
    output logic           eol,
    output logic           eof
);
    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SS   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SE   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SS   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SE   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    assign eol = (h_cnt == H_LAST);
    assign eof = eol && (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (eol) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        ctl0.vis = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        ctl0.hs  = ((h_cnt >= H_SS) && (h_cnt < H_SE)) ? SYNC_POL : ~SYNC_POL;
        ctl0.vs  = ((v_cnt >= V_SS) && (v_cnt < V_SE)) ? SYNC_POL : ~SYNC_POL;
        ctl0.fs  = (h_cnt == '0) && (v_cnt == '0);
    end
endmodule

// File: rtl/vga_scaled_scanout.sv
// vga_scaled_scanout: VGA scan-out engine for an integer-scaled framebuffer.
//   clk, rst : pixel clock, synchronous active-high reset
//   bus      : master side of vga_scaled_scanout_if (RAM read port + VGA pins)
// Pipeline: counters -> registered RAM address -> RD_LATENCY RAM clocks ->
// registered output. Sync/blank ride a RD_LATENCY+1 deep delay line so they
// leave on the same clock as the colour they belong to.
module vga_scaled_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned COLOR_W     = 8,
    parameter int unsigned RD_LATENCY  = 1,
    parameter logic        SYNC_POL    = SYNC_ACTIVE_LOW
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_scaled_scanout_if.master bus
);
    localparam int unsigned H_W   = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1);
    localparam int unsigned V_W   = $clog2(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1);
    localparam int unsigned DLY_N = RD_LATENCY + 1;

    localparam logic [ADDR_W-1:0] FB_STEP  = ADDR_W'(fb_width(H_ACTIVE, SCALE_SHIFT));
    localparam logic [V_W-1:0]    V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]    ROW_MASK = V_W'((1 << SCALE_SHIFT) - 1);
    localparam vga_ctl_t          CTL_IDLE = '{vis: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, fs: 1'b0};

    logic [H_W-1:0]     h_cnt;
    logic [V_W-1:0]     v_cnt;
    logic [V_W-1:0]     v_next;
    vga_ctl_t           ctl0;
    logic               eol;
    logic               eof;
    logic [ADDR_W-1:0]  row_base;
    vga_ctl_t           dly [DLY_N];
    logic [COLOR_W-1:0] color_next;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_timing (
        .clk   (clk),
        .rst   (rst),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .ctl0  (ctl0),
        .eol   (eol),
        .eof   (eof)
    );

    assign v_next = v_cnt + 1'b1;

    // Row base advances by one source row every 2^SCALE_SHIFT display lines,
    // replacing a v*FB_W multiply; base_addr is only taken at frame wrap so
    // a mid-frame change cannot tear the current picture.
    always_ff @(posedge clk) begin
        if (rst || eof) begin
            row_base <= bus.base_addr;
        end else if (eol && (v_next < V_ACT) && ((v_next & ROW_MASK) == '0)) begin
            row_base <= row_base + FB_STEP;
        end
    end

    // Stage 1: RAM address; wraps modulo 2^ADDR_W. Blanking addresses are
    // still computed but flagged invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.addr       <= '0;
            bus.addr_valid <= 1'b0;
        end else begin
            bus.addr       <= row_base + ADDR_W'(h_cnt >> SCALE_SHIFT);
            bus.addr_valid <= ctl0.vis;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DLY_N; i++) begin
                dly[i] <= CTL_IDLE;
            end
        end else begin
            dly[0] <= ctl0;
            for (int unsigned i = 1; i < DLY_N; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign color_next = dly[DLY_N-1].vis ? bus.color_in : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.color_out   <= '0;
            bus.active      <= 1'b0;
            bus.hsync       <= ~SYNC_POL;
            bus.vsync       <= ~SYNC_POL;
            bus.frame_start <= 1'b0;
        end else begin
            bus.color_out   <= color_next;
            bus.active      <= dly[DLY_N-1].vis;
            bus.hsync       <= dly[DLY_N-1].hs;
            bus.vsync       <= dly[DLY_N-1].vs;
            bus.frame_start <= dly[DLY_N-1].fs;
        end
    end
endmodule

// File: tb/tb_vga_scaled_scanout.sv
// tb_vga_scaled_scanout: self-checking bench for vga_scaled_scanout.
// Instance A: 8/1/2/1 x 4/1/1/1, x2 scaling, RAM latency 2, RAM returns addr.
// Instance B: default 640x480 timing, constant RAM data.
// Instance C: small timing, native scale, base near top of address space.
module tb_vga_scaled_scanout;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic [14:0] base_a = 15'h100;
    logic [14:0] base_c = 15'h7FFE;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A ----------------
    vga_scaled_scanout_if #(.ADDR_W(15), .COLOR_W(15)) a_if ();
    vga_scaled_scanout #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SCALE_SHIFT(1), .ADDR_W(15), .COLOR_W(15), .RD_LATENCY(2), .SYNC_POL(1'b0)
    ) dut_a (.clk(clk), .rst(rst_a), .bus(a_if));

    logic [14:0] ram_a1, ram_a2;
    always @(posedge clk) begin
        ram_a1 <= a_if.addr;
        ram_a2 <= ram_a1;
    end
    assign a_if.color_in  = ram_a2;
    assign a_if.base_addr = base_a;

    // ---------------- instance B ----------------
    vga_scaled_scanout_if #(.ADDR_W(15), .COLOR_W(8)) b_if ();
    vga_scaled_scanout #(
        .ADDR_W(15), .COLOR_W(8), .RD_LATENCY(1)
    ) dut_b (.clk(clk), .rst(rst_b), .bus(b_if));
    assign b_if.color_in  = 8'hA5;
    assign b_if.base_addr = 15'h0;

    // ---------------- instance C ----------------
    vga_scaled_scanout_if #(.ADDR_W(15), .COLOR_W(8)) c_if ();
    vga_scaled_scanout #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SCALE_SHIFT(0), .ADDR_W(15), .COLOR_W(8), .RD_LATENCY(1), .SYNC_POL(1'b0)
    ) dut_c (.clk(clk), .rst(rst_c), .bus(c_if));
    assign c_if.color_in  = 8'h00;
    assign c_if.base_addr = base_c;

    // ---------------- scoreboard for A ----------------
    typedef struct packed {
        logic        vis;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [14:0] addr;
    } exp_t;

    localparam exp_t IDLE_REC = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, addr: 15'h0};

    exp_t        sb_q[$];
    int unsigned n_a = 0;
    logic [14:0] frame_base_a = 15'h0;
    logic [14:0] frame_first_addr = 15'h0;
    logic [14:0] vis_log [0:31];
    int          hs_low_a = 0;
    int          vs_low_a = 0;
    int          fs_cnt_a = 0;

    // Reference for instance A: H_TOTAL 12, V_TOTAL 7, FB_W 4, rows repeat twice.
    function automatic exp_t model_a(input int unsigned pos, input logic [14:0] fb);
        int unsigned h, v, vr;
        exp_t e;
        h  = pos % 12;
        v  = (pos / 12) % 7;
        vr = (v < 4) ? v : 3;
        e.vis  = (h < 8) && (v < 4);
        e.hs   = !((h >= 9) && (h < 11));
        e.vs   = (v != 5);
        e.fs   = (h == 0) && (v == 0);
        e.addr = fb + 15'((vr >> 1) * 4 + (h >> 1));
        return e;
    endfunction

    // One reset edge on A, check reset values, then release with the
    // scoreboard primed with the three idle delay-line entries.
    task automatic reset_a;
        rst_a = 1'b1;
        @(negedge clk);
        total++;
        if (a_if.addr !== 15'h0 || a_if.addr_valid !== 1'b0 || a_if.hsync !== 1'b1 ||
            a_if.vsync !== 1'b1 || a_if.color_out !== 15'h0 || a_if.active !== 1'b0 ||
            a_if.frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_a got addr=%h av=%b hs=%b vs=%b col=%h act=%b fs=%b expected 0,0,1,1,0,0,0",
                     a_if.addr, a_if.addr_valid, a_if.hsync, a_if.vsync, a_if.color_out,
                     a_if.active, a_if.frame_start);
        end
        sb_q.delete();
        repeat (3) sb_q.push_back(IDLE_REC);
        n_a = 0;
        rst_a = 1'b0;
    endtask

    task automatic run_a(input int unsigned cycles);
        exp_t e, f;
        int unsigned pos;
        for (int unsigned k = 0; k < cycles; k++) begin
            @(negedge clk);
            n_a++;
            pos = n_a - 1;
            if (pos % 84 == 0) begin
                frame_base_a     = base_a;
                frame_first_addr = a_if.addr;
            end
            e = model_a(pos, frame_base_a);
            if (pos < 48 && e.vis) vis_log[(pos / 12) * 8 + (pos % 12)] = a_if.addr;
            total++;
            if (a_if.addr_valid !== e.vis || (e.vis && a_if.addr !== e.addr)) begin
                bad++;
                $display("FAIL addr_a pos=%0d got av=%b addr=%h expected av=%b addr=%h",
                         pos, a_if.addr_valid, a_if.addr, e.vis, e.addr);
            end
            sb_q.push_back(e);
            f = sb_q.pop_front();
            total++;
            if (a_if.active !== f.vis || a_if.hsync !== f.hs || a_if.vsync !== f.vs ||
                a_if.frame_start !== f.fs || a_if.color_out !== (f.vis ? f.addr : 15'h0)) begin
                bad++;
                $display("FAIL out_a pos=%0d got act=%b hs=%b vs=%b fs=%b col=%h expected act=%b hs=%b vs=%b fs=%b col=%h",
                         pos, a_if.active, a_if.hsync, a_if.vsync, a_if.frame_start, a_if.color_out,
                         f.vis, f.hs, f.vs, f.fs, f.vis ? f.addr : 15'h0);
            end
            if (!a_if.hsync) hs_low_a++;
            if (!a_if.vsync) vs_low_a++;
            if (a_if.frame_start) fs_cnt_a++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        base_a = 15'h100;
        reset_a();
        run_a(4);
    endtask

    task automatic test_addr_table;
        logic [14:0] tbl [0:7];
        logic [14:0] want;
        tbl = '{15'h100, 15'h100, 15'h101, 15'h101, 15'h102, 15'h102, 15'h103, 15'h103};
        base_a = 15'h100;
        reset_a();
        run_a(48);
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 8; h++) begin
                want = (v < 2) ? tbl[h] : tbl[h] + 15'h4;
                total++;
                if (vis_log[v * 8 + h] !== want) begin
                    bad++;
                    $display("FAIL addr_table v=%0d h=%0d got %h expected %h", v, h, vis_log[v * 8 + h], want);
                end
            end
        end
    endtask

    task automatic test_color_pipeline;
        run_a(200);
    endtask

    task automatic test_frame_counts;
        hs_low_a = 0;
        vs_low_a = 0;
        fs_cnt_a = 0;
        run_a(168);
        total++;
        if (hs_low_a != 28 || vs_low_a != 24 || fs_cnt_a != 2) begin
            bad++;
            $display("FAIL frame_counts got hs_low=%0d vs_low=%0d fs=%0d expected 28 24 2",
                     hs_low_a, vs_low_a, fs_cnt_a);
        end
    endtask

    task automatic test_base_change;
        run_a((40 + 84 - (n_a % 84)) % 84);
        base_a = 15'h000;
        run_a(45);
        total++;
        if (frame_first_addr !== 15'h000) begin
            bad++;
            $display("FAIL base_zero got %h expected 0000", frame_first_addr);
        end
        run_a(39);
        base_a = 15'h200;
        run_a(45);
        total++;
        if (frame_first_addr !== 15'h200) begin
            bad++;
            $display("FAIL base_change got %h expected 0200", frame_first_addr);
        end
        run_a(84);
    endtask

    task automatic test_mid_reset;
        run_a(17);
        reset_a();
        run_a(3);
        run_a(1);
        total++;
        if (a_if.active !== 1'b1 || a_if.frame_start !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_first got act=%b fs=%b expected 1 1", a_if.active, a_if.frame_start);
        end
        run_a(100);
    endtask

    task automatic test_default_timing;
        int hs_low, act, vs_low, fs, run, runs, bad_runs, col_err;
        hs_low = 0; act = 0; vs_low = 0; fs = 0; run = 0; runs = 0; bad_runs = 0; col_err = 0;
        rst_b = 1'b1;
        @(negedge clk);
        total++;
        if (b_if.hsync !== 1'b1 || b_if.vsync !== 1'b1 || b_if.active !== 1'b0 ||
            b_if.color_out !== 8'h00 || b_if.frame_start !== 1'b0 || b_if.addr !== 15'h0) begin
            bad++;
            $display("FAIL reset_b got hs=%b vs=%b act=%b col=%h fs=%b addr=%h expected 1 1 0 00 0 0000",
                     b_if.hsync, b_if.vsync, b_if.active, b_if.color_out, b_if.frame_start, b_if.addr);
        end
        rst_b = 1'b0;
        for (int unsigned k = 1; k <= 1603; k++) begin
            @(negedge clk);
            if (k < 3) begin
                total++;
                if (b_if.active !== 1'b0 || b_if.frame_start !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_b k=%0d got act=%b fs=%b expected 0 0", k, b_if.active, b_if.frame_start);
                end
            end else if (k == 3) begin
                total++;
                if (b_if.active !== 1'b1 || b_if.frame_start !== 1'b1 || b_if.color_out !== 8'hA5) begin
                    bad++;
                    $display("FAIL first_b got act=%b fs=%b col=%h expected 1 1 a5",
                             b_if.active, b_if.frame_start, b_if.color_out);
                end
            end else begin
                if (!b_if.hsync) begin
                    hs_low++;
                    run++;
                end else begin
                    if (run != 0) begin
                        runs++;
                        if (run != 96) bad_runs++;
                    end
                    run = 0;
                end
                if (b_if.active) act++;
                if (!b_if.vsync) vs_low++;
                if (b_if.frame_start) fs++;
                if (b_if.color_out !== (b_if.active ? 8'hA5 : 8'h00)) col_err++;
            end
        end
        total++;
        if (hs_low != 192 || runs != 2 || bad_runs != 0) begin
            bad++;
            $display("FAIL hsync_b got low=%0d runs=%0d bad_runs=%0d expected 192 2 0", hs_low, runs, bad_runs);
        end
        total++;
        if (act != 1280 || vs_low != 0 || fs != 0) begin
            bad++;
            $display("FAIL active_b got act=%0d vs_low=%0d fs=%0d expected 1280 0 0", act, vs_low, fs);
        end
        total++;
        if (col_err != 0) begin
            bad++;
            $display("FAIL color_b got %0d bad pixels expected 0", col_err);
        end
    endtask

    task automatic test_addr_wrap;
        logic [14:0] want [0:3];
        want = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
        base_c = 15'h7FFE;
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        for (int unsigned k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                total++;
                if (c_if.addr !== want[k-1] || c_if.addr_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL wrap_c k=%0d got av=%b addr=%h expected av=1 addr=%h",
                             k, c_if.addr_valid, c_if.addr, want[k-1]);
                end
            end else if (k == 13) begin
                total++;
                if (c_if.addr !== 15'h0006) begin
                    bad++;
                    $display("FAIL wrap_row_c got %h expected 0006", c_if.addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addr_table();
        test_color_pipeline();
        test_frame_counts();
        test_base_change();
        test_mid_reset();
        test_default_timing();
        test_addr_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_scaled_scanout.md
# vga_scaled_scanout

Parametrised VGA scan-out engine: generates H/V timing, computes framebuffer read addresses for an integer-scaled source image, and re-aligns sync/blank with memory read latency so colour, hsync and vsync leave on the same cycle. Sits between the framebuffer RAM read port and the VGA pins. Successor to the fixed 640x480, ×4, hard-offset controller: timing, scale factor, address width, colour width and RAM latency are generic, and the base address is programmable per frame.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SCALE_SHIFT, 2, log2 of pixel replication factor (0 = native)
- ADDR_W, 15, framebuffer address width
- COLOR_W, 8, colour width
- RD_LATENCY, 1, RAM clocks from address to data (≥1)
- SYNC_POL, 0, active level of hsync/vsync
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- base_addr  in  ADDR_W  address of source pixel (0,0); sampled at frame boundary
- color_in  in  COLOR_W  RAM read data
- addr  out  ADDR_W  RAM read address
- addr_valid  out  1  addr is for a visible pixel
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- color_out  out  COLOR_W  pixel colour, 0 during blanking
- active  out  1  color_out is a visible pixel
- frame_start  out  1  one-cycle pulse aligned with the first visible pixel on color_out

## Operation
- One clock; reset is synchronous and active-high. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. FB_W = H_ACTIVE >> SCALE_SHIFT.
- Stage 0: h_cnt 0..H_TOTAL-1 increments every clock; at H_TOTAL-1 wraps to 0 and v_cnt increments, wrapping 0 after V_TOTAL-1.
- vis0 = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE. hs0 = SYNC_POL when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL; vs0 same on v_cnt.
- Row base register, no multiplier: at h_cnt==H_TOTAL-1: if v_cnt==V_TOTAL-1, base_q ← base_addr and row_base ← base_addr; else if v_cnt+1 < V_ACTIVE and (v_cnt+1)[SCALE_SHIFT-1:0]==0, row_base ← row_base+FB_W; else hold.
- Stage 1 (registered): addr ← row_base + (h_cnt >> SCALE_SHIFT), modulo 2^ADDR_W (wrap, no saturation); addr_valid ← vis0. During blanking addr holds the computed value; consumers ignore it via addr_valid.
- Delay line of RD_LATENCY+1 stages carries {vis0, hs0, vs0, fs0}; fs0 = (h_cnt==0 && v_cnt==0).
- Output stage (registered): color_out ← vis ? color_in : 0; active, hsync, vsync, frame_start from delay-line tail.
- base_addr changes mid-frame take effect only at the next frame boundary (no tearing).

## Timing
- Reset values: h_cnt=v_cnt=0, row_base=base_q=base_addr, addr=0, addr_valid=0, hsync=vsync=~SYNC_POL, color_out=0, active=0, frame_start=0, delay line all inactive.
- First edge with rst low advances counters from (0,0); state (h,v) reaches outputs RD_LATENCY+2 edges after it is on the counters; addr leads color_out by RD_LATENCY+1 clocks.
- Reset asserted mid-frame: all above values on the next edge, regardless of position; no partial-line output.
- Throughput: one pixel per clock, no stalls.

## Structure
- Package vga_pkg: default timing constants (640x480@60), H_TOTAL/V_TOTAL/FB_W derivation functions, sync-polarity constants.
- Sub-module vga_timing_gen: h/v counters plus vis0/hs0/vs0/fs0 decode and end-of-line/end-of-frame strobes; address path, delay line and output stage stay in the top.

## Test plan
- Small timing (H 8/1/2/1, V 4/1/1/1, SCALE_SHIFT 1, RD_LATENCY 2, base 0x100): addr sequence on visible lines 0,1 = 0x100,0x100,0x101,0x101,0x102,0x102,0x103,0x103; lines 2,3 start at 0x104.
- RAM model returning addr as data: color_out equals the addr from exactly 3 clocks earlier whenever active=1; color_out=0 whenever active=0.
- Default 640x480: hsync low for exactly 96 clocks per 800; vsync low for exactly 2 lines per 525; frame_start once per 420000 clocks.
- base_addr changed mid-frame from 0x000 to 0x200: current frame unaffected; next frame first addr = 0x200.
- base_addr = 2^ADDR_W-2 with SCALE_SHIFT 0: addr wraps 0x7FFE,0x7FFF,0x0000.
- rst pulsed mid-line: outputs take reset values next edge; first active pixel RD_LATENCY+2 clocks after release with frame_start=1.
